// File: rtl/rng_arbiter_if.sv
// rng_arbiter_if: request/grant, reseed and LFSR signals of the random-value arbiter.
interface rng_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [9:0]  rand_out;
    logic        rand_valid;
    logic        reseed_req;
    logic [9:0]  reseed_seed;
    logic        reseed_ack;
    logic [9:0]  lfsr_seed;
    logic        lfsr_reseed_en;
    logic [9:0]  lfsr_val;
    logic        busy;
    logic [15:0] served_cnt;
    modport master (
        output req, reseed_req, reseed_seed, lfsr_val,
        input  gnt, rand_out, rand_valid, reseed_ack, lfsr_seed, lfsr_reseed_en, busy, served_cnt
    );
    modport slave (
        input  req, reseed_req, reseed_seed, lfsr_val,
        output gnt, rand_out, rand_valid, reseed_ack, lfsr_seed, lfsr_reseed_en, busy, served_cnt
    );
endinterface

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin hands out values of a shared LFSR to 4 requesters,
// with a warmup discard period after reset and after every reseed.
module rng_arbiter #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 4
) (
    input logic         clk,
    input logic         reset,
    rng_arbiter_if.slave bus
);
    localparam logic [1:0] S_WARMUP = 2'd0;
    localparam logic [1:0] S_SERVE  = 2'd1;
    localparam logic [1:0] S_RESEED = 2'd2;

    logic [1:0] state, state_nx;
    logic [7:0] cnt;
    logic [1:0] last_grant, pick, idx;
    logic       found, grant_now, accept;

    // Walk downward so the requester nearest last_grant+1 is the final (winning) assignment.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = last_grant;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last_grant + 2'(i);
            if (bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign accept    = (state == S_SERVE) && bus.reseed_req;
    assign grant_now = (state == S_SERVE) && !bus.reseed_req && found;
    assign state_nx  = (state == S_WARMUP) ? ((cnt == 8'd0) ? S_SERVE : S_WARMUP) :
                       (state == S_RESEED) ? S_WARMUP :
                       accept ? S_RESEED : S_SERVE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_WARMUP;
            cnt                <= 8'(WARMUP - 1);
            last_grant         <= 2'd3;
            bus.gnt            <= 4'd0;
            bus.rand_valid     <= 1'b0;
            bus.rand_out       <= 10'd0;
            bus.reseed_ack     <= 1'b0;
            bus.lfsr_reseed_en <= 1'b0;
            bus.lfsr_seed      <= 10'd0;
            bus.busy           <= 1'b1;
            bus.served_cnt     <= 16'd0;
        end else begin
            state              <= state_nx;
            cnt                <= (state == S_WARMUP) ? cnt - 8'd1 : 8'(WARMUP - 1);
            bus.gnt            <= grant_now ? (4'b0001 << pick) : 4'd0;
            bus.rand_valid     <= grant_now;
            bus.reseed_ack     <= accept;
            bus.lfsr_reseed_en <= accept;
            bus.busy           <= state_nx != S_SERVE;
            if (grant_now) begin
                bus.rand_out   <= bus.lfsr_val;
                last_grant     <= pick;
                bus.served_cnt <= bus.served_cnt + 16'd1;
            end
            // An all-zero seed would lock the LFSR up.
            if (accept)
                bus.lfsr_seed <= (bus.reseed_seed == 10'd0) ? 10'd1 : bus.reseed_seed;
        end
    end
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed tests of warmup, round-robin grants, reseed, reset abort and counter wrap.
module tb_rng_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] lfsr = 10'h155;
    logic [9:0] last_rand;
    int         checks = 0;
    int         errors = 0;

    rng_arbiter_if bus();
    rng_arbiter #(.NREQ(4), .WARMUP(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    // Stand-in for the shared LFSR: changes on the falling edge so it is stable at each rising edge.
    always @(negedge clk) lfsr = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    assign bus.lfsr_val = lfsr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.req = 4'd0; bus.reseed_req = 1'b0; bus.reseed_seed = 10'd0;
        tick; tick;
        checks++; if (bus.gnt !== 4'd0) begin errors++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt); end
        checks++; if (bus.rand_valid !== 1'b0) begin errors++; $display("FAIL reset_rand_valid got=%b exp=0", bus.rand_valid); end
        checks++; if (bus.rand_out !== 10'd0) begin errors++; $display("FAIL reset_rand_out got=%h exp=0", bus.rand_out); end
        checks++; if (bus.reseed_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.reseed_ack); end
        checks++; if (bus.lfsr_reseed_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", bus.lfsr_reseed_en); end
        checks++; if (bus.lfsr_seed !== 10'd0) begin errors++; $display("FAIL reset_seed got=%h exp=0", bus.lfsr_seed); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.served_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", bus.served_cnt); end
    endtask

    task automatic test_warmup_rr;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req = 4'b1111; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL warmup_busy[%0d] got=%b exp=1", i, bus.busy); end
            tick;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL serve_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.gnt !== 4'd0) begin errors++; $display("FAIL serve_entry_gnt got=%b exp=0000", bus.gnt); end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (bus.gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, bus.gnt, exp_g[i]); end
            checks++; if (bus.rand_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, bus.rand_valid); end
            checks++; if (bus.rand_out !== lfsr) begin errors++; $display("FAIL rr_rand[%0d] got=%h exp=%h", i, bus.rand_out, lfsr); end
            last_rand = lfsr;
        end
        bus.req = 4'd0;
        checks++; if (bus.served_cnt !== 16'd5) begin errors++; $display("FAIL rr_cnt got=%0d exp=5", bus.served_cnt); end
        tick;
        checks++; if (bus.gnt !== 4'd0 || bus.rand_valid !== 1'b0) begin errors++; $display("FAIL idle_gnt got=%b/%b exp=0000/0", bus.gnt, bus.rand_valid); end
        checks++; if (bus.rand_out !== last_rand) begin errors++; $display("FAIL idle_hold got=%h exp=%h", bus.rand_out, last_rand); end
    endtask

    task automatic test_alternate;
        logic [3:0] exp;
        bus.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick;
            exp = (i % 2 == 0) ? 4'b0100 : 4'b0001;
            checks++; if (bus.gnt !== exp) begin errors++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, bus.gnt, exp); end
            checks++; if (bus.rand_out !== lfsr) begin errors++; $display("FAIL alt_rand[%0d] got=%h exp=%h", i, bus.rand_out, lfsr); end
        end
        bus.req = 4'd0;
        tick;
        checks++; if (bus.served_cnt !== 16'd9) begin errors++; $display("FAIL alt_cnt got=%0d exp=9", bus.served_cnt); end
    endtask

    task automatic test_reseed;
        bus.reseed_req = 1'b1; bus.reseed_seed = 10'h2AA; bus.req = 4'b0001;
        tick;
        checks++; if (bus.gnt !== 4'd0) begin errors++; $display("FAIL reseed_prio_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.lfsr_reseed_en !== 1'b1 || bus.reseed_ack !== 1'b1) begin errors++; $display("FAIL reseed_strobe got=%b/%b exp=1/1", bus.lfsr_reseed_en, bus.reseed_ack); end
        checks++; if (bus.lfsr_seed !== 10'h2AA) begin errors++; $display("FAIL reseed_seed got=%h exp=2aa", bus.lfsr_seed); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reseed_busy got=%b exp=1", bus.busy); end
        bus.reseed_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rs_warm_busy[%0d] got=%b exp=1", i, bus.busy); end
            checks++; if (bus.lfsr_reseed_en !== 1'b0 || bus.reseed_ack !== 1'b0) begin errors++; $display("FAIL rs_warm_strobe[%0d] got=%b/%b exp=0/0", i, bus.lfsr_reseed_en, bus.reseed_ack); end
            checks++; if (bus.lfsr_seed !== 10'h2AA) begin errors++; $display("FAIL rs_seed_hold[%0d] got=%h exp=2aa", i, bus.lfsr_seed); end
        end
        tick;
        checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'd0) begin errors++; $display("FAIL rs_serve got busy=%b gnt=%b exp=0/0000", bus.busy, bus.gnt); end
        tick;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rs_gnt got=%b exp=0001", bus.gnt); end
        checks++; if (bus.served_cnt !== 16'd10) begin errors++; $display("FAIL rs_cnt got=%0d exp=10", bus.served_cnt); end
        bus.req = 4'd0;
        tick;
    endtask

    task automatic test_reseed_zero;
        bus.reseed_req = 1'b1; bus.reseed_seed = 10'd0;
        tick;
        checks++; if (bus.lfsr_seed !== 10'd1 || bus.lfsr_reseed_en !== 1'b1) begin errors++; $display("FAIL zero_seed got=%h/%b exp=001/1", bus.lfsr_seed, bus.lfsr_reseed_en); end
        bus.reseed_req = 1'b0;
    endtask

    task automatic test_reset_in_reseed;
        reset = 1'b1;
        tick;
        checks++; if (bus.lfsr_reseed_en !== 1'b0 || bus.reseed_ack !== 1'b0) begin errors++; $display("FAIL rst_rs_strobe got=%b/%b exp=0/0", bus.lfsr_reseed_en, bus.reseed_ack); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_rs_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.served_cnt !== 16'd0) begin errors++; $display("FAIL rst_rs_cnt got=%0d exp=0", bus.served_cnt); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_rs_warm[%0d] got=%b exp=1", i, bus.busy); end
            tick;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_rs_serve got=%b exp=0", bus.busy); end
    endtask

    task automatic test_wrap;
        bus.req = 4'b1111;
        repeat (65535) tick;
        checks++; if (bus.served_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffff", bus.served_cnt); end
        tick;
        checks++; if (bus.served_cnt !== 16'd0 || bus.rand_valid !== 1'b1) begin errors++; $display("FAIL wrap got=%h/%b exp=0000/1", bus.served_cnt, bus.rand_valid); end
        bus.req = 4'd0;
        tick;
        checks++; if (bus.rand_valid !== 1'b0 || bus.gnt !== 4'd0) begin errors++; $display("FAIL wrap_idle got=%b/%b exp=0/0000", bus.rand_valid, bus.gnt); end
    endtask

    initial begin
        test_reset;
        test_warmup_rr;
        test_alternate;
        test_reseed;
        test_reseed_zero;
        test_reset_in_reseed;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, the number of requesters (fixed at 4 in this revision).
REQ-002 The module SHALL have parameter WARMUP, default 4, the number of discard cycles after reset or reseed (range 1..255).
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  4  per-requester random-value request; level, held until granted.
REQ-006 gnt  out  4  one-hot grant, one-cycle pulse.
REQ-007 rand_out  out  10  random value for the granted requester, valid with gnt.
REQ-008 rand_valid  out  1  high when gnt is non-zero.
REQ-009 reseed_req  in  1  reseed request; level, held until reseed_ack.
REQ-010 reseed_seed  in  10  seed value, sampled in the accept cycle.
REQ-011 reseed_ack  out  1  one-cycle pulse on reseed acceptance.
REQ-012 lfsr_seed  out  10  seed driven to the shared 10-bit LFSR.
REQ-013 lfsr_reseed_en  out  1  LFSR load strobe, one cycle.
REQ-014 lfsr_val  in  10  current LFSR output; advances every cycle.
REQ-015 busy  out  1  high whenever state is not SERVE.
REQ-016 served_cnt  out  16  count of grants issued; wraps 0xFFFF->0.

Function
REQ-017 The FSM SHALL have states WARMUP, SERVE and RESEED; all outputs SHALL be registered.
REQ-018 WARMUP SHALL load a counter with WARMUP-1 on entry, decrement it each cycle, and go to SERVE on the cycle after it reads 0, giving exactly WARMUP cycles in WARMUP.
REQ-019 SERVE with reseed_req=1 SHALL have priority over req. The next state is RESEED, and no grant is issued that cycle.
REQ-020 When a reseed is accepted, the following cycle SHALL drive lfsr_reseed_en=1 and reseed_ack=1, and lfsr_seed SHALL equal the sampled reseed_seed.
REQ-021 A sampled reseed_seed of 0 SHALL be substituted with 10'd1 to prevent LFSR lockup.
REQ-022 RESEED SHALL last exactly one cycle and then go to WARMUP.
REQ-023 reseed_req in WARMUP SHALL be ignored until SERVE is reached.
REQ-024 SERVE with reseed_req=0 and req!=0 SHALL produce, in the next cycle, gnt = one-hot of the selected index, rand_out = lfsr_val sampled at that edge, rand_valid=1, and served_cnt+1.
REQ-025 Requester selection SHALL be round-robin: search begins at (last_grant+1) mod 4, and last_grant updates only when a grant is issued.
REQ-026 At most one grant SHALL be issued per cycle, and a requester may be granted on consecutive cycles.
REQ-027 In every cycle without a grant, gnt and rand_valid SHALL be 0 and rand_out SHALL hold its last value.
REQ-028 Outside the RESEED output cycle, lfsr_reseed_en and reseed_ack SHALL be 0, and lfsr_seed SHALL hold its last value.
REQ-029 req bits deasserted before grant SHALL be dropped without error, and no request state SHALL be stored.

Reset
REQ-030 On reset, the state SHALL be WARMUP with counter WARMUP-1 and last_grant=3, so requester 0 wins first.
REQ-031 On reset, the outputs SHALL be: gnt=0, rand_valid=0, rand_out=0, reseed_ack=0, lfsr_reseed_en=0, lfsr_seed=0, busy=1, served_cnt=0.
REQ-032 Reset asserted mid-operation SHALL abort any RESEED or grant, and the reset values SHALL apply the following cycle.

Verification
REQ-033 Release reset with req=4'b1111 -> busy=1 for exactly 4 cycles; grants then follow in order 0001, 0010, 0100, 1000, 0001; served_cnt=5.
REQ-034 Hold req=4'b0101 in SERVE -> gnt alternates 0001/0100, and each rand_out equals lfsr_val of the prior cycle.
REQ-035 reseed_req=1 with reseed_seed=10'h2AA and req=4'b0001 in the same cycle -> no gnt; the next cycle has lfsr_reseed_en=1, lfsr_seed=10'h2AA and reseed_ack=1; busy=1 for 5 cycles; then gnt=0001.
REQ-036 Reseed with reseed_seed=0 -> lfsr_seed=10'd1.
REQ-037 Assert reset during the RESEED cycle -> the next cycle shows lfsr_reseed_en=0, busy=1 and served_cnt=0, and a full 4-cycle WARMUP follows.
REQ-038 Preload served_cnt to 0xFFFF through 65535 grants, then grant once -> served_cnt=0.
